// File: rtl/div_func_unit_pkg.sv
// Shared types for the integer divide unit: op encoding, branch tags, CDB payload,
// the divider FSM states and the branch-kill rule.
package rv32i_types;

  localparam int DIV_ITERATIONS = 32;
  localparam int BR_TAG_W       = 4;

  // div_op = {signed, remainder}
  typedef enum logic [1:0] {
    DIVU = 2'b00,
    REMU = 2'b01,
    DIV  = 2'b10,
    REM  = 2'b11
  } div_op_t;

  localparam int DIV_OP_SIGNED = 1;
  localparam int DIV_OP_REM    = 0;

  typedef struct packed {
    logic                sign;
    logic [BR_TAG_W-1:0] tag;
  } branch_tag_t;

  typedef struct packed {
    logic        req;
    logic [31:0] value;
  } CDB_output_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // Same-sign flush kills ops on or under the flushed path; opposite sign kills
  // ops whose own tag is contained in the flushed tag.
  function automatic logic br_killed(branch_tag_t op_tag, branch_tag_t ft);
    if (op_tag.sign == ft.sign) return (op_tag.tag & ft.tag) == ft.tag;
    return (op_tag.tag & ft.tag) == op_tag.tag;
  endfunction

  function automatic logic [31:0] abs32(logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_func_unit_core.sv
// Radix-2 restoring divide datapath on unsigned magnitudes plus the iteration counter.
// The next-step quotient/remainder are exported so the top can sign-correct on the last step.
module div_iter_core
  import rv32i_types::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        last_o,
  output logic [31:0] quo_nxt_o,
  output logic [31:0] rem_nxt_o
);

  localparam int CNT_W = $clog2(DIV_ITERATIONS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [32:0]      shifted;
  logic             fits;

  // The partial remainder is always below the divisor, so the difference fits 32 bits.
  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    fits      = shifted >= {1'b0, dvs_q};
    rem_nxt_o = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
    quo_nxt_o = {quo_q[30:0], fits};
    last_o    = cnt_q == CNT_W'(DIV_ITERATIONS - 1);
  end

  always_comb begin
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (load_i) begin
      cnt_d = '0;
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (abort_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      quo_d = quo_nxt_o;
      rem_d = rem_nxt_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/div_func_unit.sv
// Fixed-latency 32-bit divide unit: accepts one op, iterates 32 cycles, holds the
// result on the CDB until granted; branch flushes can kill it at any point.
module div_func_unit
  import rv32i_types::*;
#(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  branch_tag_t          flush_tag,
  input  logic                 issue,
  input  logic [31:0]          operand1,
  input  logic [31:0]          operand2,
  input  branch_tag_t          br_tag_in,
  input  logic [ROB_WIDTH-1:0] dest_ROB_in,
  input  logic [1:0]           div_op,
  output logic                 running,
  output logic                 cdb_req,
  input  logic                 cdb_grant,
  output logic [31:0]          rd_v,
  output logic [ROB_WIDTH-1:0] dest_ROB_out,
  output branch_tag_t          br_tag_out
);

  div_state_t           state_q, state_d;
  branch_tag_t          tag_q, tag_d;
  logic [ROB_WIDTH-1:0] rob_q, rob_d;
  logic                 is_rem_q, is_rem_d;
  logic                 quo_neg_q, quo_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 div0_q, div0_d;
  CDB_output_t          cdb_q, cdb_d;

  logic        kill_issue, kill_cur, accept, step, abort, finish, last;
  logic        op_signed;
  logic [31:0] opa, opb, quo_nxt, rem_nxt, quo_fin, rem_fin;

  always_comb begin
    op_signed  = div_op[DIV_OP_SIGNED];
    kill_issue = flush && br_killed(br_tag_in, flush_tag);
    kill_cur   = flush && br_killed(tag_q, flush_tag);
    accept     = (state_q == IDLE) && issue && !kill_issue;
    step       = (state_q == BUSY) && !kill_cur;
    abort      = (state_q != IDLE) && kill_cur;
    finish     = step && last;
    opa        = op_signed ? abs32(operand1) : operand1;
    opb        = op_signed ? abs32(operand2) : operand2;
  end

  div_iter_core u_core (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (accept),
    .step_i     (step),
    .abort_i    (abort),
    .dividend_i (opa),
    .divisor_i  (opb),
    .last_o     (last),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  // Divide-by-zero quotient is all ones regardless of signs; the remainder path
  // already yields |dividend| and only needs the dividend's sign restored.
  always_comb begin
    quo_fin = div0_q ? 32'hFFFF_FFFF : (quo_neg_q ? (~quo_nxt + 32'd1) : quo_nxt);
    rem_fin = rem_neg_q ? (~rem_nxt + 32'd1) : rem_nxt;
  end

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    rob_d     = rob_q;
    is_rem_d  = is_rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    cdb_d     = cdb_q;

    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        if (kill_cur)  state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: if (kill_cur || cdb_grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      tag_d     = br_tag_in;
      rob_d     = dest_ROB_in;
      is_rem_d  = div_op[DIV_OP_REM];
      quo_neg_d = op_signed && (operand1[31] ^ operand2[31]);
      rem_neg_d = op_signed && operand1[31];
      div0_d    = operand2 == 32'd0;
    end

    cdb_d.req = state_d == DONE;
    if (finish) cdb_d.value = is_rem_q ? rem_fin : quo_fin;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      tag_q     <= '0;
      rob_q     <= '0;
      is_rem_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      cdb_q     <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      rob_q     <= rob_d;
      is_rem_q  <= is_rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      cdb_q     <= cdb_d;
    end
  end

  assign running      = state_q != IDLE;
  assign cdb_req      = cdb_q.req;
  assign rd_v         = cdb_q.value;
  assign dest_ROB_out = rob_q;
  assign br_tag_out   = tag_q;

endmodule

// File: tb/tb_div_func_unit.sv
// Directed and random checks of div_func_unit against an arithmetic reference model.
module tb_div_func_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst, flush, issue, cdb_grant;
  branch_tag_t flush_tag, br_tag_in, br_tag_out;
  logic [31:0] operand1, operand2, rd_v;
  logic [2:0]  dest_ROB_in, dest_ROB_out;
  logic [1:0]  div_op;
  logic        running, cdb_req;

  int checks = 0;
  int errors = 0;
  int since  = 0;

  always #5 clk = ~clk;

  div_func_unit #(.ROB_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_tag(flush_tag), .issue(issue),
    .operand1(operand1), .operand2(operand2), .br_tag_in(br_tag_in),
    .dest_ROB_in(dest_ROB_in), .div_op(div_op), .running(running),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .rd_v(rd_v),
    .dest_ROB_out(dest_ROB_out), .br_tag_out(br_tag_out)
  );

  function automatic logic [31:0] ref_div(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    since++;
  endtask

  task automatic start_op(logic [31:0] a, logic [31:0] b, logic [1:0] op,
                          branch_tag_t tag, logic [2:0] rob);
    chk("issue_idle", 32'(running), 32'd0);
    operand1 = a; operand2 = b; div_op = op; br_tag_in = tag; dest_ROB_in = rob;
    issue = 1'b1;
    tick();
    issue = 1'b0;
    since = 1;
  endtask

  task automatic wait_result(string name, logic [31:0] exp, logic [2:0] rob, branch_tag_t tag);
    while (!cdb_req && since < 40) tick();
    chk({name, "_latency"}, 32'(since), 32'd33);
    chk({name, "_value"}, rd_v, exp);
    chk({name, "_rob"}, 32'(dest_ROB_out), 32'(rob));
    chk({name, "_tag"}, 32'(br_tag_out), 32'(tag));
  endtask

  task automatic grant_it(string name);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    chk({name, "_released"}, {30'd0, running, cdb_req}, 32'd0);
  endtask

  task automatic run_op(string name, logic [31:0] a, logic [31:0] b, logic [1:0] op,
                        branch_tag_t tag, logic [2:0] rob, logic [31:0] exp);
    start_op(a, b, op, tag, rob);
    wait_result(name, exp, rob, tag);
    grant_it(name);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    branch_tag_t t;
    logic [2:0]  r;

    rst = 1'b0; flush = 1'b0; issue = 1'b0; cdb_grant = 1'b0;
    flush_tag = '0; br_tag_in = '0; operand1 = '0; operand2 = '0;
    dest_ROB_in = '0; div_op = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("reset_ctrl", {30'd0, running, cdb_req}, 32'd0);
    chk("reset_rdv", rd_v, 32'd0);
    chk("reset_rob_tag", {24'd0, dest_ROB_out, br_tag_out}, 32'd0);

    // Spec'd arithmetic cases, including divide-by-zero and signed overflow.
    run_op("divu_100_7", 32'd100, 32'd7, DIVU, '{1'b0, 4'b0001}, 3'd3, 32'd14);
    run_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, REM, '{1'b0, 4'b0010}, 3'd1, 32'hFFFF_FFFF);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, DIV, '{1'b1, 4'b0010}, 3'd2, 32'hFFFF_FFFD);
    run_op("divu_5_0", 32'd5, 32'd0, DIVU, '{1'b0, 4'b0000}, 3'd4, 32'hFFFF_FFFF);
    run_op("remu_5_0", 32'd5, 32'd0, REMU, '{1'b0, 4'b0000}, 3'd5, 32'd5);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, DIV, '{1'b0, 4'b0100}, 3'd6, 32'h8000_0000);
    run_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, REM, '{1'b0, 4'b0100}, 3'd7, 32'd0);
    run_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, DIV, '{1'b0, 4'b1000}, 3'd0, 32'hFFFF_FFFF);
    run_op("rem_m5_0", 32'hFFFF_FFFB, 32'd0, REM, '{1'b0, 4'b1000}, 3'd1, 32'hFFFF_FFFB);
    run_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, REM, '{1'b0, 4'b1000}, 3'd1, 32'd1);

    // Result held while the CDB is not granted.
    start_op(32'd1000, 32'd3, DIVU, '{1'b0, 4'b0011}, 3'd5);
    wait_result("hold", 32'd333, 3'd5, '{1'b0, 4'b0011});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_value", rd_v, 32'd333);
      chk("hold_ctrl", {29'd0, running, cdb_req, dest_ROB_out == 3'd5}, 32'd7);
    end
    grant_it("hold");

    // Matching same-sign flush at BUSY cycle 10.
    start_op(32'd77, 32'd7, DIVU, '{1'b0, 4'b0110}, 3'd2);
    repeat (9) tick();
    flush = 1'b1; flush_tag = '{1'b0, 4'b0010};
    tick();
    flush = 1'b0;
    chk("flush_busy_idle", {30'd0, running, cdb_req}, 32'd0);
    repeat (30) tick();
    chk("flush_busy_noreq", 32'(cdb_req), 32'd0);

    // Matching opposite-sign flush.
    start_op(32'd77, 32'd7, DIVU, '{1'b1, 4'b0011}, 3'd2);
    repeat (9) tick();
    flush = 1'b1; flush_tag = '{1'b0, 4'b0111};
    tick();
    flush = 1'b0;
    chk("flush_xsign_idle", {30'd0, running, cdb_req}, 32'd0);

    // Non-matching flushes, same and opposite sign, leave the op on time.
    start_op(32'd81, 32'd9, DIVU, '{1'b0, 4'b0011}, 3'd3);
    repeat (9) tick();
    flush = 1'b1; flush_tag = '{1'b0, 4'b0100};
    tick();
    flush = 1'b0;
    wait_result("nomatch_same", 32'd9, 3'd3, '{1'b0, 4'b0011});
    grant_it("nomatch_same");
    start_op(32'd81, 32'd9, REMU, '{1'b1, 4'b0101}, 3'd4);
    repeat (9) tick();
    flush = 1'b1; flush_tag = '{1'b0, 4'b0011};
    tick();
    flush = 1'b0;
    wait_result("nomatch_xsign", 32'd0, 3'd4, '{1'b1, 4'b0101});
    grant_it("nomatch_xsign");

    // Kill at issue: no accept.
    operand1 = 32'd10; operand2 = 32'd2; div_op = DIVU; br_tag_in = '{1'b0, 4'b1000};
    issue = 1'b1; flush = 1'b1; flush_tag = '{1'b0, 4'b1000};
    tick();
    issue = 1'b0; flush = 1'b0;
    chk("kill_at_issue", {30'd0, running, cdb_req}, 32'd0);

    // Kill in DONE beats a simultaneous grant.
    start_op(32'd10, 32'd2, DIVU, '{1'b0, 4'b1001}, 3'd6);
    wait_result("kill_done", 32'd5, 3'd6, '{1'b0, 4'b1001});
    flush = 1'b1; flush_tag = '{1'b0, 4'b0001}; cdb_grant = 1'b1;
    tick();
    flush = 1'b0; cdb_grant = 1'b0;
    chk("kill_done_idle", {30'd0, running, cdb_req}, 32'd0);

    // A stray issue while busy must not disturb the in-flight op.
    start_op(32'd50, 32'd5, DIVU, '{1'b0, 4'b0001}, 3'd1);
    repeat (5) tick();
    operand1 = 32'd99; operand2 = 32'd1; div_op = REMU;
    br_tag_in = '{1'b1, 4'b1111}; dest_ROB_in = 3'd7; issue = 1'b1;
    tick();
    issue = 1'b0;
    wait_result("busy_issue", 32'd10, 3'd1, '{1'b0, 4'b0001});
    grant_it("busy_issue");

    // Reset in BUSY cycle 20, then a normal op.
    start_op(32'd1234, 32'd10, DIVU, '{1'b1, 4'b0111}, 3'd7);
    repeat (19) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_busy_ctrl", {30'd0, running, cdb_req}, 32'd0);
    chk("rst_busy_data", rd_v | {24'd0, dest_ROB_out, br_tag_out}, 32'd0);
    repeat (40) tick();
    chk("rst_busy_noreq", 32'(cdb_req), 32'd0);
    run_op("after_rst", 32'd1234, 32'd10, REMU, '{1'b0, 4'b0010}, 3'd2, 32'd4);

    // Random ops with a bias toward the special cases.
    for (int n = 0; n < 24; n++) begin
      a = $urandom; b = $urandom;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        4: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      t = branch_tag_t'($urandom_range(0, 31));
      r = 3'($urandom_range(0, 7));
      run_op("random", a, b, op, t, r, ref_div(a, b, op));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
